// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch button path (debounce, button_event).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } btn_state_t;

  function automatic int ms_to_cycles(input int freq, input int ms);
    return (freq / 1000) * ms;
  endfunction

endpackage

// File: rtl/btn_hold_timer.sv
// Hold-time counter: clears on request, counts when enabled, and flags when it
// sits on the terminal value chosen by the caller.
module btn_hold_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             at_terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign at_terminal = (count == terminal);

endmodule

// File: rtl/button_event.sv
// Turns the debounced button level into single-cycle press / release / short /
// long / auto-repeat pulses for the stopwatch control FSM.
module button_event
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam int LONG_CYCLES   = ms_to_cycles(CLK_FREQ, LONG_MS);
  localparam int REPEAT_CYCLES = ms_to_cycles(CLK_FREQ, REPEAT_MS);
  localparam int MAX_CYCLES    = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W         = $clog2(MAX_CYCLES + 1);
  localparam bit REPEAT_EN     = (REPEAT_CYCLES > 0);

  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_EN ? REPEAT_CYCLES - 1 : 0);

  generate
    if (LONG_CYCLES < 2) begin : g_bad_long
      $error("button_event: LONG_CYCLES must be at least 2");
    end
  endgenerate

  btn_state_t       state, state_next;
  logic             btn_q;
  logic             rise, fall;
  logic             timer_clear, timer_enable, at_terminal;
  logic [CNT_W-1:0] terminal;
  logic             press_next, release_next, short_next, long_next, repeat_next;

  assign rise     = btn_level & ~btn_q;
  assign fall     = ~btn_level & btn_q;
  assign terminal = (state == PRESSED) ? LONG_TERM : REPEAT_TERM;
  assign held     = (state != IDLE);

  btn_hold_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (timer_clear),
    .enable     (timer_enable),
    .terminal   (terminal),
    .at_terminal(at_terminal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      btn_q         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_next;
      btn_q         <= btn_level;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      short_press   <= short_next;
      long_press    <= long_next;
      repeat_pulse  <= repeat_next;
    end
  end

  // A release always wins over a threshold reached in the same cycle.
  always_comb begin
    state_next   = state;
    press_next   = 1'b0;
    release_next = 1'b0;
    short_next   = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          press_next  = 1'b1;
          timer_clear = 1'b1;
          state_next  = PRESSED;
        end
      end
      PRESSED: begin
        if (fall) begin
          release_next = 1'b1;
          short_next   = 1'b1;
          timer_clear  = 1'b1;
          state_next   = IDLE;
        end else if (at_terminal) begin
          long_next   = 1'b1;
          timer_clear = 1'b1;
          state_next  = LONG_HELD;
        end else begin
          timer_enable = 1'b1;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          release_next = 1'b1;
          timer_clear  = 1'b1;
          state_next   = IDLE;
        end else if (REPEAT_EN) begin
          if (at_terminal) begin
            repeat_next = 1'b1;
            timer_clear = 1'b1;
          end else begin
            timer_enable = 1'b1;
          end
        end
      end
      default: begin
        timer_clear = 1'b1;
        state_next  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_event.sv
// Directed self-checking bench for button_event (LONG_CYCLES=20, REPEAT_CYCLES=10,
// plus a second instance with repeat disabled).
module tb_button_event;

  // Output vector bit order: {press, release, short, long, repeat, held}
  typedef struct {
    logic       btn;
    logic [5:0] exp;
  } vec_t;

  logic clk;
  logic reset_n;
  logic btn_level;

  logic press_pulse, release_pulse, short_press, long_press, repeat_pulse, held;
  logic nr_press, nr_release, nr_short, nr_long, nr_repeat, nr_held;

  int checks_total;
  int checks_passed;

  vec_t vecs[15];

  button_event #(
    .CLK_FREQ (10000),
    .LONG_MS  (2),
    .REPEAT_MS(1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_press  (short_press),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  button_event #(
    .CLK_FREQ (10000),
    .LONG_MS  (2),
    .REPEAT_MS(0)
  ) dut_norep (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_level    (btn_level),
    .press_pulse  (nr_press),
    .release_pulse(nr_release),
    .short_press  (nr_short),
    .long_press   (nr_long),
    .repeat_pulse (nr_repeat),
    .held         (nr_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs_main();
    return {press_pulse, release_pulse, short_press, long_press, repeat_pulse, held};
  endfunction

  function automatic logic [5:0] outs_norep();
    return {nr_press, nr_release, nr_short, nr_long, nr_repeat, nr_held};
  endfunction

  // Drive the level, let one rising edge sample it, then settle before checking.
  task automatic applyStimulus(input logic b);
    btn_level = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %b expected %b (press,rel,short,long,rep,held)", name, got, exp);
    end
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;

    // Short press (5 cycles high), then back-to-back pattern 1,1,1,0,1,1,0
    vecs[0]  = '{1'b1, 6'b100001};
    vecs[1]  = '{1'b1, 6'b000001};
    vecs[2]  = '{1'b1, 6'b000001};
    vecs[3]  = '{1'b1, 6'b000001};
    vecs[4]  = '{1'b1, 6'b000001};
    vecs[5]  = '{1'b0, 6'b011000};
    vecs[6]  = '{1'b0, 6'b000000};
    vecs[7]  = '{1'b1, 6'b100001};
    vecs[8]  = '{1'b1, 6'b000001};
    vecs[9]  = '{1'b1, 6'b000001};
    vecs[10] = '{1'b0, 6'b011000};
    vecs[11] = '{1'b1, 6'b100001};
    vecs[12] = '{1'b1, 6'b000001};
    vecs[13] = '{1'b0, 6'b011000};
    vecs[14] = '{1'b0, 6'b000000};

    reset_n   = 1'b0;
    btn_level = 1'b0;
    #23;
    checkOutput("reset_main", outs_main(), 6'b000000);
    checkOutput("reset_norep", outs_norep(), 6'b000000);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].btn);
      checkOutput($sformatf("table[%0d]", i), outs_main(), vecs[i].exp);
    end

    // Long press with auto-repeat, released after 45 cycles
    for (int j = 0; j < 45; j++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("long_rep[%0d]", j), outs_main(),
                  {(j == 0), 1'b0, 1'b0, (j == 20), (j == 30 || j == 40), 1'b1});
    end
    applyStimulus(1'b0);
    checkOutput("long_rep_release", outs_main(), 6'b010000);
    applyStimulus(1'b0);
    checkOutput("long_rep_idle", outs_main(), 6'b000000);

    // Release on the very cycle the long threshold would be hit
    for (int j = 0; j < 20; j++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("race[%0d]", j), outs_main(), {(j == 0), 5'b00001});
    end
    applyStimulus(1'b0);
    checkOutput("race_release", outs_main(), 6'b011000);
    applyStimulus(1'b0);
    checkOutput("race_idle", outs_main(), 6'b000000);

    // Repeat disabled: one long press, no repeats over a 60 cycle hold
    for (int j = 0; j < 60; j++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("norep[%0d]", j), outs_norep(),
                  {(j == 0), 1'b0, 1'b0, (j == 20), 1'b0, 1'b1});
    end
    applyStimulus(1'b0);
    checkOutput("norep_release", outs_norep(), 6'b010000);
    applyStimulus(1'b0);

    // Reset in the middle of a hold
    for (int j = 0; j < 13; j++) begin
      applyStimulus(1'b1);
    end
    checkOutput("pre_reset_held", outs_main(), 6'b000001);
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_main", outs_main(), 6'b000000);
    checkOutput("async_reset_norep", outs_norep(), 6'b000000);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    reset_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0);
      checkOutput($sformatf("post_reset_quiet[%0d]", j), outs_main(), 6'b000000);
    end

    // Button already high when reset releases
    btn_level = 1'b1;
    reset_n   = 1'b0;
    applyStimulus(1'b1);
    checkOutput("held_in_reset", outs_main(), 6'b000000);
    reset_n = 1'b1;
    applyStimulus(1'b1);
    checkOutput("press_after_reset", outs_main(), 6'b100001);
    applyStimulus(1'b0);
    checkOutput("release_after_reset", outs_main(), 6'b011000);

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
